// File: rtl/systolic_feed_sequencer.sv
// Sequencer for a weight-stationary PE array: loads weight columns, skews activation
// vectors into the rows and deskews the column partial sums into aligned result vectors.
module systolic_feed_sequencer #(
    parameter int unsigned ARRAY_SIZE        = 8,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned PARTIAL_SUM_WIDTH = 24,
    parameter int unsigned PSUM_LATENCY      = 8,
    parameter int unsigned VEC_CNT_WIDTH     = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [VEC_CNT_WIDTH-1:0]                num_vectors,
    input  logic [ARRAY_SIZE-1:0]                   pe_disable_in,
    input  logic                                    w_valid,
    output logic                                    w_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]        w_data,
    input  logic                                    a_valid,
    output logic                                    a_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]        a_data,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]        weight_out,
    output logic                                    weight_shift,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]        act_out,
    output logic [ARRAY_SIZE-1:0]                   pe_disable_out,
    input  logic [ARRAY_SIZE*PARTIAL_SUM_WIDTH-1:0] psum_in,
    output logic                                    result_valid,
    output logic [ARRAY_SIZE*PARTIAL_SUM_WIDTH-1:0] result_data,
    output logic                                    busy,
    output logic                                    done
);

    localparam int unsigned L      = PSUM_LATENCY + ARRAY_SIZE + 1;
    localparam int unsigned WCNT_W = $clog2(ARRAY_SIZE) + 1;

    typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

    state_e                         state_q, state_d;
    logic [VEC_CNT_WIDTH-1:0]       num_q, vec_cnt_q, res_cnt_q, res_cnt_d;
    logic [WCNT_W-1:0]              w_cnt_q;
    logic [ARRAY_SIZE-1:0]          dis_q;
    logic [L-1:0]                   strobe_q;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_out_q;
    logic                           weight_shift_q;
    logic                           w_acc, a_acc, start_pass;

    assign w_ready        = (state_q == StLoadW);
    assign a_ready        = (state_q == StStream);
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign w_acc          = w_valid & w_ready;
    assign a_acc          = a_valid & a_ready;
    assign start_pass     = (state_q == StIdle) & start;
    assign result_valid   = strobe_q[L-1];
    assign res_cnt_d      = res_cnt_q + VEC_CNT_WIDTH'(result_valid);
    assign weight_out     = weight_out_q;
    assign weight_shift   = weight_shift_q;
    assign pe_disable_out = dis_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StLoadW;
            StLoadW: begin
                if (w_acc && (w_cnt_q == WCNT_W'(ARRAY_SIZE - 1))) begin
                    state_d = (num_q == '0) ? StDone : StStream;
                end
            end
            StStream: if (a_acc && ((vec_cnt_q + VEC_CNT_WIDTH'(1)) == num_q)) state_d = StDrain;
            // Include this cycle's strobe so done follows the final result by one cycle.
            StDrain:  if (res_cnt_d == num_q) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            num_q          <= '0;
            vec_cnt_q      <= '0;
            res_cnt_q      <= '0;
            w_cnt_q        <= '0;
            dis_q          <= '0;
            strobe_q       <= '0;
            weight_out_q   <= '0;
            weight_shift_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            strobe_q       <= {strobe_q[L-2:0], a_acc};
            weight_shift_q <= w_acc;
            if (w_acc) weight_out_q <= w_data;
            if (start_pass) begin
                num_q     <= num_vectors;
                dis_q     <= pe_disable_in;
                vec_cnt_q <= '0;
                res_cnt_q <= '0;
                w_cnt_q   <= '0;
            end else begin
                if (w_acc) w_cnt_q <= w_cnt_q + WCNT_W'(1);
                if (a_acc) vec_cnt_q <= vec_cnt_q + VEC_CNT_WIDTH'(1);
                res_cnt_q <= res_cnt_d;
            end
        end
    end

    // Row k sees its lane k+1 cycles after the accept; idle cycles inject zeros.
    for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_skew
        logic [DATA_WIDTH-1:0] pipe_q [k+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) pipe_q[j] <= '0;
            end else begin
                pipe_q[0] <= a_acc ? a_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int j = 1; j <= k; j++) pipe_q[j] <= pipe_q[j-1];
            end
        end
        assign act_out[k*DATA_WIDTH +: DATA_WIDTH] = pipe_q[k];
    end

    // Column i: ARRAY_SIZE-1-i delay stages plus the output register.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_deskew
        logic [PARTIAL_SUM_WIDTH-1:0] pipe_q [ARRAY_SIZE-i];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < int'(ARRAY_SIZE - i); j++) pipe_q[j] <= '0;
            end else begin
                pipe_q[0] <= psum_in[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH];
                for (int j = 1; j < int'(ARRAY_SIZE - i); j++) pipe_q[j] <= pipe_q[j-1];
            end
        end
        assign result_data[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] =
            dis_q[i] ? '0 : pipe_q[ARRAY_SIZE-1-i];
    end

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Scoreboard bench for systolic_feed_sequencer with a loopback array model.
module tb_systolic_feed_sequencer;

    localparam int AS  = 8;
    localparam int DW  = 8;
    localparam int PSW = 24;
    localparam int PL  = 8;
    localparam int VCW = 8;
    localparam int LAT = PL + AS + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [VCW-1:0]   num_vectors = '0;
    logic [AS-1:0]    pe_disable_in = '0;
    logic             w_valid = 1'b0, w_ready;
    logic [AS*DW-1:0] w_data = '0;
    logic             a_valid = 1'b0, a_ready;
    logic [AS*DW-1:0] a_data = '0;
    logic [AS*DW-1:0] weight_out, act_out;
    logic             weight_shift, result_valid, busy, done;
    logic [AS-1:0]    pe_disable_out;
    logic [AS*PSW-1:0] psum_in, result_data;

    always #5 clk = ~clk;

    systolic_feed_sequencer #(
        .ARRAY_SIZE(AS), .DATA_WIDTH(DW), .PARTIAL_SUM_WIDTH(PSW),
        .PSUM_LATENCY(PL), .VEC_CNT_WIDTH(VCW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .pe_disable_in(pe_disable_in), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .weight_out(weight_out), .weight_shift(weight_shift), .act_out(act_out),
        .pe_disable_out(pe_disable_out), .psum_in(psum_in), .result_valid(result_valid),
        .result_data(result_data), .busy(busy), .done(done)
    );

    // Loopback array: each act_out lane returns PL cycles later, zero-extended.
    logic [AS*DW-1:0] hist [PL];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PL; i++) hist[i] <= '0;
        end else begin
            hist[0] <= act_out;
            for (int i = 1; i < PL; i++) hist[i] <= hist[i-1];
        end
    end
    always_comb begin
        psum_in = '0;
        for (int i = 0; i < AS; i++) psum_in[i*PSW +: PSW] = PSW'(hist[PL-1][i*DW +: DW]);
    end

    typedef struct { logic [AS*PSW-1:0] data; int cyc; } res_t;
    typedef struct { logic [AS*DW-1:0] data; int cyc; } w_t;
    res_t sb[$];
    w_t   wq[$];
    res_t mon_r;
    w_t   mon_w;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int last_res_cyc = 0, last_w_cyc = 0, res_seen = 0, done_seen = 0, a_ready_seen = 0;
    logic act_chk = 1'b0, mask_chk = 1'b0;
    logic [AS-1:0] mask_exp = '0;
    logic [AS*DW-1:0] inj [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [AS*DW-1:0] vec(input int base, input int v);
        logic [AS*DW-1:0] r;
        for (int k = 0; k < AS; k++) r[k*DW +: DW] = DW'(base + 8*v + k);
        return r;
    endfunction

    function automatic logic [AS*DW-1:0] wcol(input int col);
        logic [AS*DW-1:0] r;
        for (int k = 0; k < AS; k++) r[k*DW +: DW] = DW'(16*col + k);
        return r;
    endfunction

    function automatic logic [AS*PSW-1:0] exp_res(input logic [AS*DW-1:0] a,
                                                  input logic [AS-1:0] m);
        logic [AS*PSW-1:0] r;
        for (int k = 0; k < AS; k++) r[k*PSW +: PSW] = m[k] ? '0 : PSW'(a[k*DW +: DW]);
        return r;
    endfunction

    // Monitor: scoreboard pops and timing/side checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid) begin
                res_seen++;
                last_res_cyc = cyc;
                if (sb.size() == 0) begin
                    check("result_unexpected", 1, 0);
                end else begin
                    mon_r = sb.pop_front();
                    check("result_data", result_data, mon_r.data);
                    check("result_cycle", cyc, mon_r.cyc);
                end
            end
            if (weight_shift) begin
                if (wq.size() == 0) begin
                    check("weight_shift_unexpected", 1, 0);
                end else begin
                    mon_w = wq.pop_front();
                    check("weight_out", weight_out, mon_w.data);
                    check("weight_shift_cycle", cyc, mon_w.cyc);
                end
            end
            if (done) done_seen++;
            if (a_ready) a_ready_seen++;
            if (mask_chk && busy) check("pe_disable_out", pe_disable_out, mask_exp);
            if (act_chk) begin
                logic [AS*DW-1:0] e;
                for (int k = 0; k < AS; k++) e[k*DW +: DW] = inj[cyc-k][k*DW +: DW];
                check("act_out_skew", act_out, e);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {w_ready, a_ready, weight_shift, result_valid, busy, done}, 0);
        check({tag, "_weight_out"}, weight_out, 0);
        check({tag, "_act_out"}, act_out, 0);
        check({tag, "_result_data"}, result_data, 0);
        check({tag, "_pe_disable_out"}, pe_disable_out, 0);
    endtask

    task automatic do_start(input int n, input logic [AS-1:0] m);
        res_seen      = 0;
        start         = 1'b1;
        num_vectors   = VCW'(n);
        pe_disable_in = m;
        @(negedge clk);
        start = 1'b0;
        check("w_ready_rise", w_ready, 1);
    endtask

    // Columns go in last-array-column first; bubbles after columns 2 and 4.
    task automatic load_weights();
        for (int c = 0; c < AS; c++) begin
            int g = 0;
            if (c == 3 || c == 5) begin
                w_valid = 1'b0;
                @(negedge clk);
            end
            w_valid = 1'b1;
            w_data  = wcol(AS - 1 - c);
            while (!w_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!w_ready) check("w_ready_timeout", 0, 1);
            wq.push_back('{data: w_data, cyc: cyc + 1});
            last_w_cyc = cyc;
            @(negedge clk);
        end
        w_valid = 1'b0;
    endtask

    task automatic stream(input int base, input logic [AS-1:0] m, input bit toggle,
                          input bit hold, input int max_acc);
        int acc = 0, slot = 0;
        while (acc < max_acc && slot < 500) begin
            if (toggle && slot % 2 == 1) begin
                a_valid = 1'b0;
            end else begin
                a_valid = 1'b1;
                a_data  = vec(base, acc);
            end
            if (a_valid && a_ready) begin
                sb.push_back('{data: exp_res(a_data, m), cyc: cyc + LAT});
                inj[cyc+1] = a_data;
                acc++;
            end
            slot++;
            @(negedge clk);
        end
        if (acc < max_acc) check("a_ready_timeout", acc, max_acc);
        if (hold) begin
            check("a_ready_drop", a_ready, 0);
            repeat (3) @(negedge clk);
        end
        a_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int g = 0;
        while (!done && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (!done) check("done_timeout", 0, 1);
        else check("done_cycle", cyc, (n > 0) ? last_res_cyc + 1 : last_w_cyc + 1);
        @(negedge clk);
        check("idle_after_done", {busy, done}, 0);
    endtask

    task automatic run_pass(input int n, input logic [AS-1:0] m, input int base,
                            input bit toggle, input bit hold);
        do_start(n, m);
        load_weights();
        if (n > 0) stream(base, m, toggle, hold, n);
        wait_done(n);
        repeat (3) @(negedge clk);
        check("result_count", res_seen, n);
        check("queues_empty", sb.size() + wq.size(), 0);
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 4096; i++) inj[i] = '0;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full 8-vector pass; a_valid held after the last accept.
        run_pass(8, '0, 0, 1'b0, 1'b1);
        check("weight_out_final", weight_out, 64'h0706050403020100);
        check("w_ready_after_load", w_ready, 0);

        // Alternating a_valid with full skew check.
        act_chk = 1'b1;
        run_pass(4, '0, 8'h80, 1'b1, 1'b0);
        act_chk = 1'b0;

        // Disabled columns 0 and 2.
        mask_exp = 8'h05;
        mask_chk = 1'b1;
        run_pass(8, 8'h05, 8'h40, 1'b0, 1'b0);
        mask_chk = 1'b0;

        // Zero-vector pass.
        snap = a_ready_seen;
        run_pass(0, '0, 0, 1'b0, 1'b0);
        check("a_ready_never", a_ready_seen - snap, 0);

        // Reset in the middle of STREAM after three accepts.
        do_start(5, '0);
        load_weights();
        stream(8'h10, '0, 1'b0, 1'b0, 3);
        #2 rst = 1'b1;
        #1 check_all_zero("midpass_reset");
        sb.delete();
        wq.delete();
        @(negedge clk);
        rst  = 1'b0;
        snap = done_seen;
        repeat (30) @(negedge clk);
        check("no_done_after_reset", done_seen - snap, 0);

        run_pass(2, '0, 8'h20, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
